lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, maximum cycles in ACCESS waiting for dm_ack_i before timeout error (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  1  core requests one load/store access; sampled only in IDLE.
REQ-005 mem_write_i  input  1  1 = store, 0 = load (MemWrite from decoder).
REQ-006 load_sel_i  input  4  access kind: 0 lw/sw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 sb, 6 sh.
REQ-007 addr_i  input  32  byte address from ALU.
REQ-008 wdata_i  input  32  store data (rt value).
REQ-009 busy_o  output  1  stall to core; high whenever state != IDLE.
REQ-010 done_o  output  1  one-cycle pulse, access finished (success or error).
REQ-011 rdata_o  output  32  formatted load result; held until next successful load.
REQ-012 err_o  output  2  valid with done_o: 00 ok, 01 misaligned, 10 timeout, 11 illegal kind.
REQ-013 dm_req_o  output  1  memory request, held until ack.
REQ-014 dm_we_o  output  1  memory write strobe, valid with dm_req_o.
REQ-015 dm_be_o  output  4  byte enables, bit n = byte lane n (little-endian).
REQ-016 dm_addr_o  output  32  word address, {addr[31:2],2'b00}.
REQ-017 dm_wdata_o  output  32  lane-replicated store data.
REQ-018 dm_ack_i  input  1  memory accepted/completed access; dm_rdata_i valid same cycle.
REQ-019 dm_rdata_i  input  32  read word.

Function
REQ-020 States SHALL be IDLE, ACCESS, DONE, ERR; IDLE->ACCESS on req_i with legal aligned access, IDLE->ERR on req_i with illegal or misaligned access, ACCESS->DONE on dm_ack_i, ACCESS->ERR on timeout, DONE/ERR->IDLE unconditionally.
REQ-021 On accepting req_i, addr, kind, mem_write and wdata SHALL be latched; inputs are don't-care afterwards.
REQ-022 req_i outside IDLE SHALL be ignored (no queuing).
REQ-023 Illegal kind: load_sel 7..15; mem_write=1 with sel 1..4; mem_write=0 with sel 5..6 -> err 11.
REQ-024 Misaligned: word access with addr[1:0]!=0; half access (lh, lhu, sh) with addr[0]=1 -> err 01; illegal check takes priority over misalignment.
REQ-025 dm_req_o SHALL be high exactly in ACCESS, with dm_addr_o/dm_we_o/dm_be_o/dm_wdata_o stable from latched values throughout.
REQ-026 Loads: dm_be_o=1111, dm_we_o=0; stores: dm_we_o=1.
REQ-027 sw be=1111; sh be=0011 if addr[1]=0 else 1100, wdata={2{wdata[15:0]}}; sb be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
REQ-028 Load formatting at ack: lw whole word; lb/lbu byte lane addr[1:0], sign-/zero-extended; lh/lhu half lane addr[1], sign-/zero-extended; registered into rdata_o on the ack edge.
REQ-029 Stores and errors SHALL NOT modify rdata_o.
REQ-030 Latency: ack in first ACCESS cycle -> done_o two cycles after req_i; each wait cycle adds one.
REQ-031 Timeout counter: 8 bits, cleared on ACCESS entry, increments each ACCESS cycle without ack; ack on cycle where count reaches ACK_TIMEOUT wins over timeout.
REQ-032 done_o high in DONE (err 00) and in ERR (err per cause); err_o 00 whenever done_o low.
REQ-033 Errored accesses SHALL never assert dm_req_o.

Reset
REQ-034 rstn low SHALL immediately force IDLE, dm_req_o=0, dm_we_o=0, dm_be_o=0, dm_addr_o=0, dm_wdata_o=0, busy_o=0, done_o=0, err_o=00, rdata_o=0, counter=0, including mid-ACCESS (in-flight access abandoned, no done_o).

Verification
REQ-035 lb addr 0x103, dm_rdata 0x80FF_1234, ack in first ACCESS cycle -> dm_addr 0x100, be 1111, rdata_o 0xFFFF_FF80, done_o at cycle 2, err 00.
REQ-036 sh addr 0x206, wdata 0xDEAD_BEEF -> dm_addr 0x204, be 1100, dm_wdata 0xBEEF_BEEF, we=1; rdata_o unchanged.
REQ-037 lw addr 0x102 -> no dm_req_o, done_o with err 01; sel 3 with mem_write=1 -> err 11.
REQ-038 lhu addr 0x002, ack withheld -> dm_req_o held ACK_TIMEOUT cycles, then done_o err 10; ack delayed 3 cycles instead -> done_o at cycle 5, rdata_o = zero-extended upper half.
REQ-039 rstn low during ACCESS wait, req_i pulses while busy -> outputs zero immediately, no done_o, later req_i accepted normally; busy-time req_i produces no extra access.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one MIPS-style load or store per request, driving a word-wide data memory port.
// Latency: done_o two cycles after an accepted req_i when ack arrives in the first ACCESS cycle, plus one per wait cycle.
// Backpressure: busy_o stalls the core outside IDLE; req_i is ignored while busy, and dm_req_o is held until dm_ack_i.
//
// Ports: clk/rstn; core side req_i, mem_write_i, load_sel_i, addr_i, wdata_i -> busy_o, done_o, rdata_o, err_o;
//        memory side dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o <- dm_ack_i, dm_rdata_i.
module lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        mem_write_i,
    input  logic [3:0]  load_sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  err_o,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [3:0] SEL_W   = 4'd0;
    localparam logic [3:0] SEL_LB  = 4'd1;
    localparam logic [3:0] SEL_LBU = 4'd2;
    localparam logic [3:0] SEL_LH  = 4'd3;
    localparam logic [3:0] SEL_LHU = 4'd4;
    localparam logic [3:0] SEL_SB  = 4'd5;
    localparam logic [3:0] SEL_SH  = 4'd6;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // Count value of the last ACCESS cycle before giving up; ACCESS lasts ACK_TIMEOUT cycles at most.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [7:0]  cnt_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;

    // Request classification, evaluated on the live inputs while IDLE.
    logic req_illegal;
    logic req_misal;

    always_comb begin
        req_illegal = 1'b0;
        if (load_sel_i > SEL_SH)
            req_illegal = 1'b1;
        else if (mem_write_i && (load_sel_i >= SEL_LB) && (load_sel_i <= SEL_LHU))
            req_illegal = 1'b1;
        else if (!mem_write_i && (load_sel_i >= SEL_SB))
            req_illegal = 1'b1;
    end

    always_comb begin
        req_misal = 1'b0;
        if (load_sel_i == SEL_W)
            req_misal = (addr_i[1:0] != 2'b00);
        else if ((load_sel_i == SEL_LH) || (load_sel_i == SEL_LHU) || (load_sel_i == SEL_SH))
            req_misal = addr_i[0];
    end

    // Store lane steering from the latched request.
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
        case (sel_q)
            SEL_SB: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            SEL_SH: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Load formatting of the word returned with the ack.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        ld_byte = 8'(dm_rdata_i >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
        case (sel_q)
            SEL_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            SEL_LBU: ld_fmt = {24'd0, ld_byte};
            SEL_LH:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            SEL_LHU: ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dm_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i)
                    state_d = (req_illegal || req_misal) ? ERR : ACCESS;
            end
            ACCESS: begin
                // Ack on the final allowed cycle still completes normally.
                if (dm_ack_i)
                    state_d = DONE;
                else if (cnt_q == CNT_LAST)
                    state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        sel_q   <= load_sel_i;
                        we_q    <= mem_write_i;
                        cnt_q   <= '0;
                        err_q   <= req_illegal ? ERR_ILLEGAL :
                                   req_misal   ? ERR_MISALGN : ERR_OK;
                    end
                end
                ACCESS: begin
                    if (dm_ack_i) begin
                        if (!we_q)
                            rdata_q <= ld_fmt;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic in_access;
    assign in_access = (state_q == ACCESS);

    // Memory port is quiet (all zero) outside ACCESS, so reset and error paths never leak a request.
    assign dm_req_o   = in_access;
    assign dm_we_o    = in_access && we_q;
    assign dm_be_o    = in_access ? (we_q ? st_be : 4'b1111) : 4'b0000;
    assign dm_addr_o  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dm_wdata_o = (in_access && we_q) ? st_wdata : 32'd0;

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE) || (state_q == ERR);
    assign err_o   = (state_q == ERR) ? err_q : ERR_OK;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam int T = 255;
    localparam int NEVER = 1000;

    logic        clk;
    logic        rstn;
    logic        req_i;
    logic        mem_write_i;
    logic [3:0]  load_sel_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [1:0]  err_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_model;

    lsu #(.ACK_TIMEOUT(T)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_i      (req_i),
        .mem_write_i(mem_write_i),
        .load_sel_i (load_sel_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_be_o    (dm_be_o),
        .dm_addr_o  (dm_addr_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_ack_i   (dm_ack_i),
        .dm_rdata_i (dm_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mem;
        int          delay;
        logic [1:0]  err;
        logic [3:0]  be;
        logic [31:0] wdx;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] fmt;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the access rules: size/offset arithmetic on the byte address.
    function automatic exp_t model(input logic we, input logic [3:0] sel,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] mem);
        exp_t        e;
        int          size;
        int          off;
        bit          legal;
        logic [31:0] mask;
        logic [31:0] v;
        off   = int'(addr % 4);
        size  = (sel == 0) ? 4 : (sel == 1 || sel == 2 || sel == 5) ? 1 : 2;
        legal = (sel <= 6) && ((sel == 0) || (we ? (sel >= 5) : (sel <= 4)));
        e.err = !legal ? 2'd3 : ((off % size) != 0) ? 2'd1 : 2'd0;
        e.be  = we ? 4'(((1 << size) - 1) << off) : 4'hF;
        e.wd  = (size == 4) ? wd :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 :
                              (wd & 32'hFF) * 32'h0101_0101;
        mask  = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        v     = (mem >> (8 * off)) & mask;
        if ((sel == 1 || sel == 3) && (v >= (mask + 32'd1) / 2))
            v = v | ~mask;
        e.fmt = v;
        return e;
    endfunction

    // One access from request to completion plus one idle cycle, checked against expectations.
    task automatic do_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] mem, input int delay,
                             input bit busy_req, input logic [1:0] exp_err, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                             input string tag);
        int          exp_done, exp_req;
        int          req_cyc = 0;
        int          done_cyc = -1;
        logic [1:0]  err_seen = 2'bxx;
        logic [31:0] rd_seen = 'x;
        logic [31:0] a0 = '0, wd0 = '0;
        logic [3:0]  be0 = '0;
        logic        we0 = 1'b0;
        int          unstable = 0;
        if (exp_err[0]) begin
            exp_done = 1; exp_req = 0;
        end else if (delay < T) begin
            exp_done = 2 + delay; exp_req = delay + 1;
        end else begin
            exp_done = T + 1; exp_req = T;
        end
        @(negedge clk);
        req_i = 1'b1; mem_write_i = we; load_sel_i = sel; addr_i = addr; wdata_i = wd;
        for (int c = 1; c <= T + 5; c++) begin
            @(negedge clk);
            req_i = busy_req;
            mem_write_i = 1'($urandom); load_sel_i = 4'($urandom);
            addr_i = $urandom; wdata_i = $urandom;
            dm_ack_i = 1'b0; dm_rdata_i = $urandom;
            if (done_o) begin
                done_cyc = c; err_seen = err_o; rd_seen = rdata_o;
                req_i = 1'b0;
                break;
            end
            if (dm_req_o) begin
                if (req_cyc == 0) begin
                    a0 = dm_addr_o; be0 = dm_be_o; we0 = dm_we_o; wd0 = dm_wdata_o;
                end else if (a0 !== dm_addr_o || be0 !== dm_be_o || we0 !== dm_we_o
                             || wd0 !== dm_wdata_o) begin
                    unstable++;
                end
                if (req_cyc == delay) begin
                    dm_ack_i = 1'b1; dm_rdata_i = mem;
                end
                req_cyc++;
            end
        end
        req_i = 1'b0; dm_ack_i = 1'b0;
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, " err"}, 32'(err_seen), 32'(exp_err));
        chk({tag, " req_cycles"}, 32'(req_cyc), 32'(exp_req));
        chk({tag, " rdata"}, rd_seen, exp_rdata);
        if (exp_req > 0) begin
            chk({tag, " dm_addr"}, a0, addr & 32'hFFFF_FFFC);
            chk({tag, " dm_be"}, 32'(be0), 32'(exp_be));
            chk({tag, " dm_we"}, 32'(we0), 32'(we));
            chk({tag, " unstable"}, 32'(unstable), 32'd0);
            if (we)
                chk({tag, " dm_wdata"}, wd0, exp_wd);
        end
        @(negedge clk);
        chk({tag, " idle_after"}, {28'd0, busy_o, done_o, dm_req_o, |err_o}, 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        exp_t e;
        int   n_rst_act;
        rstn = 1'b0; req_i = 1'b0; mem_write_i = 1'b0; load_sel_i = '0;
        addr_i = '0; wdata_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;

        vecs[0]  = '{1'b0, 4'd1, 32'h103, 32'h0,        32'h80FF_1234, 0,     2'd0, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 4'd6, 32'h206, 32'hDEAD_BEEF, 32'h0,        0,     2'd0, 4'hC, 32'hBEEF_BEEF, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 4'd0, 32'h102, 32'h0,        32'h0,         0,     2'd1, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 4'd3, 32'h100, 32'h0,        32'h0,         0,     2'd3, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[4]  = '{1'b0, 4'd4, 32'h002, 32'h0,        32'hCAFE_1234, 3,     2'd0, 4'hF, 32'h0,        32'h0000_CAFE};
        vecs[5]  = '{1'b0, 4'd3, 32'h010, 32'h0,        32'h1234_8001, 1,     2'd0, 4'hF, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{1'b0, 4'd2, 32'h021, 32'h0,        32'h1122_8344, 0,     2'd0, 4'hF, 32'h0,        32'h0000_0083};
        vecs[7]  = '{1'b1, 4'd5, 32'h032, 32'h0000_00A5, 32'h0,        2,     2'd0, 4'h4, 32'hA5A5_A5A5, 32'h0000_0083};
        vecs[8]  = '{1'b1, 4'd0, 32'h040, 32'h1234_5678, 32'h0,        0,     2'd0, 4'hF, 32'h1234_5678, 32'h0000_0083};
        vecs[9]  = '{1'b0, 4'd9, 32'h040, 32'h0,        32'h0,         0,     2'd3, 4'hF, 32'h0,        32'h0000_0083};
        vecs[10] = '{1'b0, 4'd5, 32'h040, 32'h0,        32'h0,         0,     2'd3, 4'hF, 32'h0,        32'h0000_0083};
        vecs[11] = '{1'b1, 4'd6, 32'h101, 32'h0,        32'h0,         0,     2'd1, 4'hF, 32'h0,        32'h0000_0083};
        vecs[12] = '{1'b0, 4'd0, 32'h044, 32'h0,        32'hA5A5_5A5A, 0,     2'd0, 4'hF, 32'h0,        32'hA5A5_5A5A};
        vecs[13] = '{1'b0, 4'd4, 32'h002, 32'h0,        32'h0,         NEVER, 2'd2, 4'hF, 32'h0,        32'hA5A5_5A5A};
        vecs[14] = '{1'b0, 4'd0, 32'h008, 32'h0,        32'h0BAD_F00D, T - 1, 2'd0, 4'hF, 32'h0,        32'h0BAD_F00D};

        #12;
        chk("reset_outputs", {busy_o, done_o, err_o, dm_req_o, dm_we_o, dm_be_o},
            32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wd, vecs[i].mem,
                      vecs[i].delay, bit'(i % 2), vecs[i].err, vecs[i].be, vecs[i].wdx,
                      vecs[i].rdata, $sformatf("vec%0d", i));
        end
        rd_model = vecs[14].rdata;

        // Reset in the middle of an ACCESS wait, with req_i pulsing while busy.
        @(negedge clk);
        req_i = 1'b1; mem_write_i = 1'b0; load_sel_i = 4'd4; addr_i = 32'h2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_i = 1'b1; addr_i = $urandom & 32'hFFFF_FFFC; load_sel_i = 4'd0;
        end
        chk("rst_pre_req", {31'd0, dm_req_o}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_ctrl", {busy_o, done_o, err_o, dm_req_o, dm_we_o, dm_be_o}, 32'd0);
        chk("rst_addr", dm_addr_o, 32'd0);
        chk("rst_wdata", dm_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        req_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_rst_act = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_o || dm_req_o || busy_o) n_rst_act++;
        end
        chk("rst_no_activity", 32'(n_rst_act), 32'd0);
        rd_model = '0;
        do_access(1'b1, 4'd0, 32'h300, 32'h5555_AAAA, 32'h0, 1, 1'b1, 2'd0, 4'hF,
                  32'h5555_AAAA, 32'd0, "post_rst_sw");
        do_access(1'b0, 4'd1, 32'h301, 32'h0, 32'h0000_7F00, 0, 1'b0, 2'd0, 4'hF,
                  32'h0, 32'h0000_007F, "post_rst_lb");
        rd_model = 32'h0000_007F;

        // Randomized accesses against the reference model.
        for (int r = 0; r < 200; r++) begin
            logic        we;
            logic [3:0]  sel;
            logic [31:0] addr, wd, mem;
            int          dly;
            we   = 1'($urandom);
            sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            wd   = $urandom;
            mem  = $urandom;
            dly  = $urandom_range(0, 4);
            e = model(we, sel, addr, wd, mem);
            if (e.err == 2'd0 && !we) rd_model = e.fmt;
            do_access(we, sel, addr, wd, mem, dly, bit'($urandom_range(0, 1)), e.err, e.be,
                      e.wd, rd_model, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
